// File: rtl/wb_retire_queue.sv
// Writeback/retire stage: in-order retire queue between MEM and the GPR/CSR/TLB
// commit ports, with exception, ertn and refetch arbitration into one flush.
module wb_retire_queue #(
  parameter int DEPTH     = 2,
  parameter int EXC_W     = 14,
  parameter int CSR_NUM_W = 14
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mem_to_wb_valid,
  output logic                         wb_allowin,
  input  logic [31:0]                  mem_pc,
  input  logic                         mem_rf_we,
  input  logic [4:0]                   mem_rf_waddr,
  input  logic [31:0]                  mem_rf_wdata,
  input  logic                         mem_csr_re,
  input  logic                         mem_csr_we,
  input  logic [CSR_NUM_W-1:0]         mem_csr_num,
  input  logic [31:0]                  mem_csr_mask,
  input  logic [31:0]                  mem_csr_wvalue,
  input  logic [EXC_W-1:0]             mem_exc,
  input  logic                         mem_ertn,
  input  logic [31:0]                  mem_fault_vaddr,
  input  logic [2:0]                   mem_tlb_op,
  input  logic                         retire_stall,
  output logic                         csr_re,
  output logic [CSR_NUM_W-1:0]         csr_rd_num,
  input  logic [31:0]                  csr_rd_value,
  output logic                         csr_we,
  output logic [CSR_NUM_W-1:0]         csr_wr_num,
  output logic [31:0]                  csr_wr_mask,
  output logic [31:0]                  csr_wr_value,
  output logic                         rf_we,
  output logic [4:0]                   rf_waddr,
  output logic [31:0]                  rf_wdata,
  output logic                         wb_valid,
  output logic [31:0]                  wb_pc,
  output logic [EXC_W-1:0]             wb_exc,
  output logic [31:0]                  wb_fault_vaddr,
  output logic                         ertn_flush,
  output logic                         refetch_flush,
  output logic [31:0]                  refetch_pc,
  output logic                         tlb_wr,
  output logic                         tlb_fill,
  output logic                         tlb_rd,
  output logic                         flush_any,
  output logic [31:0]                  pend_mask,
  output logic [$clog2(DEPTH+1)-1:0]   wb_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) ptr_inc = '0;
    else                        ptr_inc = p + PTR_W'(1);
  endfunction

  // CSRs whose update changes translation state seen by already-fetched code.
  function automatic logic is_refetch_csr(input logic [CSR_NUM_W-1:0] n);
    is_refetch_csr = (n == CSR_NUM_W'(32'h000)) || (n == CSR_NUM_W'(32'h018)) ||
                     (n == CSR_NUM_W'(32'h180)) || (n == CSR_NUM_W'(32'h181));
  endfunction

  logic [PTR_W-1:0]     head_p0, tail_p0;
  logic [CNT_W-1:0]     cnt_p0;
  logic [DEPTH-1:0]     vld_p0;

  logic [31:0]          pc_p0      [DEPTH];
  logic                 rf_we_p0   [DEPTH];
  logic [4:0]           waddr_p0   [DEPTH];
  logic [31:0]          wdata_p0   [DEPTH];
  logic                 csr_re_p0  [DEPTH];
  logic                 csr_we_p0  [DEPTH];
  logic [CSR_NUM_W-1:0] csr_num_p0 [DEPTH];
  logic [31:0]          mask_p0    [DEPTH];
  logic [31:0]          wvalue_p0  [DEPTH];
  logic [EXC_W-1:0]     exc_p0     [DEPTH];
  logic                 ertn_p0    [DEPTH];
  logic [31:0]          fault_p0   [DEPTH];
  logic [2:0]           tlb_p0     [DEPTH];
  logic                 refetch_p0 [DEPTH];
  logic                 pend_p0    [DEPTH];

  logic retire, enq, h_exc_nz;

  assign wb_valid   = (cnt_p0 != '0);
  assign retire     = wb_valid & ~retire_stall;
  assign wb_allowin = (cnt_p0 < CNT_W'(DEPTH)) | retire;
  assign enq        = mem_to_wb_valid & wb_allowin & ~flush_any;
  assign wb_count   = cnt_p0;
  assign h_exc_nz   = |exc_p0[head_p0];

  // ---- stage p0: queue storage (data not reset, only control) ----
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_p0[tail_p0]      <= mem_pc;
      rf_we_p0[tail_p0]   <= mem_rf_we;
      waddr_p0[tail_p0]   <= mem_rf_waddr;
      wdata_p0[tail_p0]   <= mem_rf_wdata;
      csr_re_p0[tail_p0]  <= mem_csr_re;
      csr_we_p0[tail_p0]  <= mem_csr_we;
      csr_num_p0[tail_p0] <= mem_csr_num;
      mask_p0[tail_p0]    <= mem_csr_mask;
      wvalue_p0[tail_p0]  <= mem_csr_wvalue;
      exc_p0[tail_p0]     <= mem_exc;
      ertn_p0[tail_p0]    <= mem_ertn;
      fault_p0[tail_p0]   <= mem_fault_vaddr;
      tlb_p0[tail_p0]     <= mem_tlb_op;
      refetch_p0[tail_p0] <= (mem_csr_we & is_refetch_csr(mem_csr_num)) | (|mem_tlb_op);
      pend_p0[tail_p0]    <= mem_rf_we & ~(|mem_exc) & (mem_rf_waddr != 5'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush_any) begin
      head_p0 <= '0;
      tail_p0 <= '0;
      cnt_p0  <= '0;
      vld_p0  <= '0;
    end else begin
      // Retire clears before enqueue sets, so a full DEPTH=1 slot stays valid.
      if (retire) begin
        head_p0          <= ptr_inc(head_p0);
        vld_p0[head_p0]  <= 1'b0;
      end
      if (enq) begin
        tail_p0          <= ptr_inc(tail_p0);
        vld_p0[tail_p0]  <= 1'b1;
      end
      case ({enq, retire})
        2'b10:   cnt_p0 <= cnt_p0 + CNT_W'(1);
        2'b01:   cnt_p0 <= cnt_p0 - CNT_W'(1);
        default: cnt_p0 <= cnt_p0;
      endcase
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_p0[i] && pend_p0[i]) pend_mask = pend_mask | (32'd1 << waddr_p0[i]);
    end
  end

  // ---- stage p1: head commit and flush arbitration (exc > ertn > refetch) ----
  always_comb begin
    csr_re         = 1'b0;
    csr_rd_num     = '0;
    csr_we         = 1'b0;
    csr_wr_num     = '0;
    csr_wr_mask    = '0;
    csr_wr_value   = '0;
    rf_we          = 1'b0;
    rf_waddr       = '0;
    rf_wdata       = '0;
    wb_pc          = '0;
    wb_exc         = '0;
    wb_fault_vaddr = '0;
    ertn_flush     = 1'b0;
    refetch_flush  = 1'b0;
    refetch_pc     = '0;
    tlb_wr         = 1'b0;
    tlb_fill       = 1'b0;
    tlb_rd         = 1'b0;
    flush_any      = 1'b0;
    if (wb_valid) begin
      wb_pc          = pc_p0[head_p0];
      wb_exc         = exc_p0[head_p0];
      wb_fault_vaddr = fault_p0[head_p0];
      csr_rd_num     = csr_num_p0[head_p0];
    end
    if (retire) begin
      if (h_exc_nz) begin
        flush_any = 1'b1;
      end else begin
        rf_we        = rf_we_p0[head_p0] & (waddr_p0[head_p0] != 5'd0);
        rf_waddr     = waddr_p0[head_p0];
        rf_wdata     = csr_re_p0[head_p0] ? csr_rd_value : wdata_p0[head_p0];
        csr_re       = csr_re_p0[head_p0];
        csr_we       = csr_we_p0[head_p0];
        csr_wr_num   = csr_num_p0[head_p0];
        csr_wr_mask  = mask_p0[head_p0];
        csr_wr_value = wvalue_p0[head_p0];
        tlb_wr       = tlb_p0[head_p0][2];
        tlb_fill     = tlb_p0[head_p0][1];
        tlb_rd       = tlb_p0[head_p0][0];
        if (ertn_p0[head_p0]) begin
          ertn_flush = 1'b1;
          flush_any  = 1'b1;
        end else if (refetch_p0[head_p0]) begin
          refetch_flush = 1'b1;
          refetch_pc    = pc_p0[head_p0] + 32'd4;
          flush_any     = 1'b1;
        end
      end
    end
  end

endmodule
